// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one transaction at a time, with alignment checking and a ready timeout.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_e;

  localparam int unsigned   SW         = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned   TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          we_q, we_d, resp_d_q, resp_d_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          if_err_q, if_err_d, d_err_q, d_err_d;
  logic          if_gnt, d_gnt, if_legal, d_legal, d_pick;

  assign if_legal = (bus.if_addr_i[1:0] == 2'b00);
  assign d_legal  = ((bus.d_be_i == 4'b1111) && (bus.d_addr_i[1:0] == 2'b00))
                 || (((bus.d_be_i == 4'b0011) || (bus.d_be_i == 4'b1100)) && !bus.d_addr_i[0])
                 || (bus.d_be_i == 4'b0001) || (bus.d_be_i == 4'b0010)
                 || (bus.d_be_i == 4'b0100) || (bus.d_be_i == 4'b1000);
  // Data wins unless it has starved a waiting fetch for MAX_D_STREAK grants.
  assign d_pick   = bus.d_req_i && !(bus.if_req_i && (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every _d starts from its _q value so no branch leaves a latch behind.
    state_d    = state_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    resp_d_d   = resp_d_q;
    if_rdata_d = if_rdata_q;
    if_err_d   = if_err_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;

    case (state_q)
      IDLE: if (!reset_i) begin
        if (d_pick) begin
          d_gnt    = 1'b1;
          resp_d_d = 1'b1;
          addr_d   = {bus.d_addr_i[31:2], 2'b00};
          we_d     = bus.d_we_i;
          be_d     = bus.d_be_i;
          wdata_d  = bus.d_wdata_i;
          tmo_d    = '0;
          if (!bus.if_req_i)               streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
          if (d_legal) state_d = BUSY_D;
          else begin
            state_d   = RESP;
            d_rdata_d = '0;
            d_err_d   = 1'b1;
          end
        end else if (bus.if_req_i) begin
          if_gnt   = 1'b1;
          resp_d_d = 1'b0;
          addr_d   = {bus.if_addr_i[31:2], 2'b00};
          we_d     = 1'b0;
          be_d     = 4'b1111;
          wdata_d  = '0;
          tmo_d    = '0;
          streak_d = '0;
          if (if_legal) state_d = BUSY_IF;
          else begin
            state_d    = RESP;
            if_rdata_d = '0;
            if_err_d   = 1'b1;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ready_i) begin
          state_d = RESP;
          if (state_q == BUSY_IF) begin
            if_rdata_d = bus.mem_rdata_i;
            if_err_d   = 1'b0;
          end else begin
            d_rdata_d = we_q ? '0 : bus.mem_rdata_i;
            d_err_d   = 1'b0;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          if (state_q == BUSY_IF) begin
            if_rdata_d = '0;
            if_err_d   = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      resp_d_q   <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      resp_d_q   <= resp_d_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.mem_req_o   = (state_q == BUSY_IF) || (state_q == BUSY_D);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_rvalid_o = (state_q == RESP) && !resp_d_q;
  assign bus.d_rvalid_o  = (state_q == RESP) && resp_d_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_err_o    = if_err_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.d_err_o     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-schedule model checks
// every cycle, and directed scenarios pin latencies, grant order and reset.
module tb_mem_port_arbiter;
  localparam int MAX_D = 4;
  localparam int TMO   = 16;

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; int lat; } req_t;
  typedef struct { int cyc; logic is_d; } gev_t;
  typedef struct { int cyc; logic is_d; logic [31:0] rdata; logic err; } rev_t;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus)
  );

  int   n_chk = 0, n_pass = 0, cyc = 0;
  bit   chk_en = 0, stray_en = 0;
  req_t if_q[$], d_q[$];
  gev_t gnt_log[$];
  rev_t resp_log[$];
  int   if_lat_cur = 1, d_lat_cur = 1, memreq_cycles = 0;

  // Model state: absolute-cycle schedule of the one transaction in flight.
  int          m_free_at = 0, m_busy_from = 0, m_busy_to = -1, m_resp_at = -1, m_lat = 1, streak = 0;
  logic        m_is_d = 0, m_we = 0, m_res_err = 0;
  logic [3:0]  m_be = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_res_rdata = 0;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;
  logic        e_if_err = 0, e_d_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic bit legal_data(input logic [3:0] be, input logic [31:0] a);
    case (be)
      4'b1111:                            return a[1:0] == 2'b00;
      4'b0011, 4'b1100:                   return a[0] == 1'b0;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic gev_t g_at(input int i);
    gev_t none = '{cyc: -1000, is_d: 1'bx};
    return (i < gnt_log.size()) ? gnt_log[i] : none;
  endfunction

  function automatic rev_t r_at(input int i);
    rev_t none = '{cyc: -1000, is_d: 1'bx, rdata: 'x, err: 1'bx};
    return (i < resp_log.size()) ? resp_log[i] : none;
  endfunction

  // Fetch requester: holds if_req_i until granted, drops it the cycle after.
  int n_if_wait;
  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (if_q.size() == 0) bus.if_req_i = 0;
      else begin
        bus.if_req_i = 1; bus.if_addr_i = if_q[0].addr; if_lat_cur = if_q[0].lat;
        n_if_wait = 0;
        do begin @(negedge clk_i); n_if_wait++; end while (!bus.if_gnt_o && n_if_wait < 300);
        if (!bus.if_gnt_o) check("if_gnt_wait", bus.if_gnt_o, 1);
        void'(if_q.pop_front());
      end
    end
  end

  // Load/store requester.
  int n_d_wait;
  initial begin
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_be_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (d_q.size() == 0) bus.d_req_i = 0;
      else begin
        bus.d_req_i = 1; bus.d_we_i = d_q[0].we; bus.d_be_i = d_q[0].be;
        bus.d_addr_i = d_q[0].addr; bus.d_wdata_i = d_q[0].wdata; d_lat_cur = d_q[0].lat;
        n_d_wait = 0;
        do begin @(negedge clk_i); n_d_wait++; end while (!bus.d_gnt_o && n_d_wait < 300);
        if (!bus.d_gnt_o) check("d_gnt_wait", bus.d_gnt_o, 1);
        void'(d_q.pop_front());
      end
    end
  end

  // Compare process, log collection and memory responder, all on the falling edge.
  int mem_cnt = 0;
  initial begin
    logic e_ig, e_dg, busy, ok;
    int   c, nb;
    bus.mem_ready_i = 0; bus.mem_rdata_i = 0;
    forever begin
      @(negedge clk_i);
      c = cyc;
      e_ig = 0; e_dg = 0;
      if (!reset_i && c >= m_free_at) begin
        if (bus.d_req_i && !(bus.if_req_i && streak == MAX_D)) e_dg = 1;
        else if (bus.if_req_i)                                  e_ig = 1;
      end
      busy = (c >= m_busy_from) && (c <= m_busy_to);
      if (c == m_resp_at) begin
        if (m_is_d) begin e_d_rdata = m_res_rdata; e_d_err = m_res_err; end
        else        begin e_if_rdata = m_res_rdata; e_if_err = m_res_err; end
      end
      if (chk_en) begin
        check("if_gnt", bus.if_gnt_o, e_ig);
        check("d_gnt", bus.d_gnt_o, e_dg);
        check("mem_req", bus.mem_req_o, busy);
        if (busy) begin
          check("mem_addr", bus.mem_addr_o, {m_addr[31:2], 2'b00});
          check("mem_we", bus.mem_we_o, m_we);
          if (m_is_d) begin
            check("mem_be", bus.mem_be_o, m_be);
            check("mem_wdata", bus.mem_wdata_o, m_wdata);
          end
        end
        check("if_rvalid", bus.if_rvalid_o, (c == m_resp_at) && !m_is_d);
        check("d_rvalid", bus.d_rvalid_o, (c == m_resp_at) && m_is_d);
        check("if_rdata", bus.if_rdata_o, e_if_rdata);
        check("if_err", bus.if_err_o, e_if_err);
        check("d_rdata", bus.d_rdata_o, e_d_rdata);
        check("d_err", bus.d_err_o, e_d_err);
      end
      if (bus.if_gnt_o === 1'b1) gnt_log.push_back('{cyc: c, is_d: 1'b0});
      if (bus.d_gnt_o === 1'b1)  gnt_log.push_back('{cyc: c, is_d: 1'b1});
      if (bus.if_rvalid_o === 1'b1) resp_log.push_back('{cyc: c, is_d: 1'b0, rdata: bus.if_rdata_o, err: bus.if_err_o});
      if (bus.d_rvalid_o === 1'b1)  resp_log.push_back('{cyc: c, is_d: 1'b1, rdata: bus.d_rdata_o, err: bus.d_err_o});

      if (reset_i) begin
        m_free_at = c + 1; m_busy_from = 0; m_busy_to = -1; m_resp_at = -1; streak = 0;
        e_if_rdata = 0; e_if_err = 0; e_d_rdata = 0; e_d_err = 0;
      end else if (e_dg || e_ig) begin
        m_is_d = e_dg;
        if (e_dg) begin
          m_addr = bus.d_addr_i; m_we = bus.d_we_i; m_be = bus.d_be_i; m_wdata = bus.d_wdata_i;
          m_lat = d_lat_cur; ok = legal_data(m_be, m_addr);
          streak = bus.if_req_i ? ((streak < MAX_D) ? streak + 1 : streak) : 0;
        end else begin
          m_addr = bus.if_addr_i; m_we = 0; m_be = 4'hF; m_wdata = 0;
          m_lat = if_lat_cur; ok = (m_addr[1:0] == 2'b00); streak = 0;
        end
        nb = !ok ? 0 : ((m_lat == 0 || m_lat > TMO) ? TMO : m_lat);
        m_busy_from = c + 1; m_busy_to = c + nb; m_resp_at = c + nb + 1; m_free_at = c + nb + 2;
        if (!ok || m_lat == 0 || m_lat > TMO) begin m_res_rdata = 0; m_res_err = 1; end
        else if (m_is_d && m_we)              begin m_res_rdata = 0; m_res_err = 0; end
        else begin m_res_rdata = rd_fn({m_addr[31:2], 2'b00}); m_res_err = 0; end
      end

      if (bus.mem_req_o === 1'b1) begin
        mem_cnt++; memreq_cycles++;
        bus.mem_ready_i = (mem_cnt == m_lat);
        bus.mem_rdata_i = (mem_cnt == m_lat) ? rd_fn(bus.mem_addr_o) : 32'hDEAD_BEEF;
      end else begin
        mem_cnt = 0;
        bus.mem_ready_i = stray_en;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
      end
      cyc++;
    end
  end

  task automatic push_if(input logic [31:0] a, input int lat);
    if_q.push_back('{we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0, lat: lat});
  endtask

  task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    d_q.push_back('{we: we, be: be, addr: a, wdata: wd, lat: lat});
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (n < 400 && !(if_q.size() == 0 && d_q.size() == 0 && !bus.if_req_i && !bus.d_req_i
                        && cyc > m_free_at)) begin
      @(negedge clk_i); n++;
    end
    if (n >= 400) check("quiet_wait", bus.mem_req_o | bus.if_req_i | bus.d_req_i, 0);
    repeat (2) @(negedge clk_i);
  endtask

  int g0, r0, mq0, nerr, nw;
  bit exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
  initial begin
    reset_i = 1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 0; chk_en = 1;
    @(negedge clk_i);
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_be", bus.mem_be_o, 0);
    check("rst_rvalids", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
    check("rst_rdata", bus.if_rdata_o | bus.d_rdata_o, 0);

    // Fetch 0x100, ready on the second busy cycle.
    g0 = gnt_log.size(); r0 = resp_log.size(); mq0 = memreq_cycles;
    push_if(32'h100, 2); wait_quiet();
    check("t1_gnt_port", g_at(g0).is_d, 0);
    check("t1_latency", r_at(r0).cyc - g_at(g0).cyc, 3);
    check("t1_rdata", r_at(r0).rdata, 32'h0050_0093);
    check("t1_err", r_at(r0).err, 0);
    check("t1_memreq_cycles", memreq_cycles - mq0, 2);

    // Simultaneous fetch and load: data first, fetch right after the data response.
    g0 = gnt_log.size(); r0 = resp_log.size();
    push_if(32'h200, 1); push_d(0, 4'hF, 32'h2000, 0, 1); wait_quiet();
    check("t2_first_d", g_at(g0).is_d, 1);
    check("t2_second_if", g_at(g0 + 1).is_d, 0);
    check("t2_if_after_dresp", g_at(g0 + 1).cyc - r_at(r0).cyc, 1);
    check("t2_d_rdata", r_at(r0).rdata, 32'h5A5A_2000);

    // Fetch held against six stores: the streak limit lets the fetch in after four.
    g0 = gnt_log.size();
    push_if(32'h300, 1);
    for (int i = 0; i < 6; i++) push_d(1, 4'hF, 32'h400 + 4 * i, 32'h1111_0000 + i, 1);
    wait_quiet();
    for (int i = 0; i < 7; i++) check("t3_order", g_at(g0 + i).is_d, exp_order[i]);

    // Misaligned word load: immediate error, memory untouched.
    g0 = gnt_log.size(); r0 = resp_log.size(); mq0 = memreq_cycles;
    push_d(0, 4'hF, 32'h2002, 0, 1); wait_quiet();
    check("t4_latency", r_at(r0).cyc - g_at(g0).cyc, 1);
    check("t4_err", r_at(r0).err, 1);
    check("t4_memreq_cycles", memreq_cycles - mq0, 0);

    // Memory never ready: timeout after 16 busy cycles.
    g0 = gnt_log.size(); r0 = resp_log.size(); mq0 = memreq_cycles;
    push_d(0, 4'hF, 32'h3000, 0, 0); wait_quiet();
    check("t5_memreq_cycles", memreq_cycles - mq0, 16);
    check("t5_latency", r_at(r0).cyc - g_at(g0).cyc, 17);
    check("t5_err", r_at(r0).err, 1);
    check("t5_rdata", r_at(r0).rdata, 0);

    // Ready on the very last busy cycle still completes normally.
    g0 = gnt_log.size(); r0 = resp_log.size();
    push_d(0, 4'hF, 32'h3004, 0, 16); wait_quiet();
    check("t6_latency", r_at(r0).cyc - g_at(g0).cyc, 17);
    check("t6_err", r_at(r0).err, 0);
    check("t6_rdata", r_at(r0).rdata, 32'h5A5A_3004);

    // Byte-enable legality mix with stray ready pulses outside busy states.
    r0 = resp_log.size(); stray_en = 1;
    push_d(0, 4'b0011, 32'h3002, 0, 1);
    push_d(0, 4'b1100, 32'h3001, 0, 2);
    push_d(0, 4'b0100, 32'h3003, 0, 1);
    push_d(1, 4'b0010, 32'h0041, 32'hCAFE_F00D, 3);
    push_d(0, 4'b0000, 32'h0050, 0, 1);
    push_if(32'h102, 1); push_if(32'h104, 1);
    wait_quiet(); stray_en = 0;
    nerr = 0;
    for (int i = 0; i < 7; i++) nerr += (r_at(r0 + i).err === 1'b1) ? 1 : 0;
    check("t7_resp_count", resp_log.size() - r0, 7);
    check("t7_err_count", nerr, 3);

    // Reset while a load is stuck waiting on memory.
    g0 = gnt_log.size(); r0 = resp_log.size();
    push_d(0, 4'hF, 32'h5000, 0, 0);
    nw = 0;
    while (gnt_log.size() == g0 && nw < 50) begin @(negedge clk_i); nw++; end
    check("t8_granted", gnt_log.size() - g0, 1);
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1;
    @(posedge clk_i);
    #1 reset_i = 0;
    @(negedge clk_i);
    check("t8_mem_req", bus.mem_req_o, 0);
    check("t8_d_rvalid", bus.d_rvalid_o, 0);
    check("t8_d_rdata", bus.d_rdata_o, 0);
    check("t8_d_err", bus.d_err_o, 0);
    check("t8_mem_addr", bus.mem_addr_o, 0);
    repeat (20) @(negedge clk_i);
    check("t8_no_resp", resp_log.size() - r0, 0);
    g0 = gnt_log.size(); r0 = resp_log.size();
    push_if(32'h100, 1); wait_quiet();
    check("t8_post_gnt", g_at(g0).is_d, 0);
    check("t8_post_latency", r_at(r0).cyc - g_at(g0).cyc, 2);
    check("t8_post_rdata", r_at(r0).rdata, 32'h0050_0093);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d passed of %0d)", n_pass, n_chk);
    $fatal(1);
  end
endmodule
